uart_tx_peripheral: RTL

- Memory-mapped UART transmitter. It is a bus responder that sits on one peripheral slot behind the core-side address decoder/router.
- Accepts word-register reads and writes from the core, buffers transmit bytes in a FIFO, and serialises them 8N1 on a single tx line.
- Read data is returned word-aligned. The router performs byte/half extraction and sign extension.

---
 rtl/uart_tx_peripheral.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers, transmit FIFO,
// and a serialiser whose bit period is DIVISOR+1 clocks.
module uart_tx_peripheral #(
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [1:0]  size,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic        empty, full, push, pop, overflow, baud_end, tx_n;
  logic [15:0] divisor, baud_cnt, baud_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [1:0]  reg_idx;
  logic        unused_bits;
  state_t      state, state_n;

  assign reg_idx     = address[3:2];
  assign unused_bits = ^{address[31:4], address[1:0], size, write_data[31:16]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push     = write_enable && (reg_idx == 2'd0) && !full;
  assign wr_ptr_n = wr_ptr + {{PW{1'b0}}, push};
  assign rd_ptr_n = rd_ptr + {{PW{1'b0}}, pop};
  assign baud_end = (baud_cnt == 16'd0);

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    case (state)
      IDLE:  if (!empty) begin
               pop     = 1'b1;
               state_n = START;
             end
      START: if (baud_end) begin
               state_n   = DATA;
               bit_idx_n = 3'd0;
             end
      DATA:  if (baud_end) begin
               shift_n   = {1'b0, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
             end
      STOP:  if (baud_end) begin
               if (!empty) begin
                 pop     = 1'b1;
                 state_n = START;
               end else begin
                 state_n = IDLE;
               end
             end
      default: state_n = IDLE;
    endcase
    if (pop) shift_n = fifo_mem[rd_ptr[PW-1:0]];
    // Reload at every bit boundary so a divisor change lands on the next bit.
    if (pop || (state != IDLE && baud_end)) baud_cnt_n = divisor;
    else if (state != IDLE)                 baud_cnt_n = baud_cnt - 16'd1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= write_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIVISOR;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      irq      <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
      irq      <= (wr_ptr_n == rd_ptr_n) && (state_n == IDLE);
      if (write_enable && reg_idx == 2'd0 && full)                    overflow <= 1'b1;
      else if (write_enable && reg_idx == 2'd1 && write_data[3])      overflow <= 1'b0;
      if (write_enable && reg_idx == 2'd2) divisor <= write_data[15:0];
    end
  end

  always_comb begin
    read_data = '0;
    if (read_enable) begin
      case (reg_idx)
        2'd1:    read_data = {28'd0, overflow, state != IDLE, full, empty};
        2'd2:    read_data = {16'd0, divisor};
        default: read_data = '0;
      endcase
    end
  end

endmodule
